// File: rtl/port_alloc_scheduler.sv
// Write-port group allocator: round-robin start of free port groups, optional
// third-operand port reservation, and in-order tracking of outstanding memory ops.
module port_alloc_scheduler #(
  parameter int W_PORTS_NUM = 4,
  parameter int MEM_DEPTH   = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           instr_vld_i,
  input  logic [1:0]                     instr_class_i,
  input  logic                           op3_req_i,
  input  logic                           vrf_addr_vld_i,
  input  logic [W_PORTS_NUM-1:0]         dep_issue_i,
  input  logic [W_PORTS_NUM-1:0]         port_done_i,
  output logic                           instr_rdy_o,
  output logic [W_PORTS_NUM-1:0]         start_o,
  output logic [$clog2(W_PORTS_NUM)-1:0] alloc_port_o,
  output logic [$clog2(W_PORTS_NUM)-1:0] op3_port_sel_o,
  output logic                           op3_port_vld_o,
  output logic [$clog2(W_PORTS_NUM)-1:0] mem_driver_o,
  output logic                           mem_driver_vld_o,
  output logic                           mem_is_store_o,
  output logic                           all_idle_o
);

  localparam int PW  = $clog2(W_PORTS_NUM);
  localparam int MPW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW  = $clog2(MEM_DEPTH + 1);

  typedef enum logic [1:0] {
    CLS_ARITH  = 2'd0,
    CLS_STORE  = 2'd1,
    CLS_LOAD   = 2'd2,
    CLS_CONFIG = 2'd3
  } instr_class_e;

  typedef struct packed {
    logic [PW-1:0] port;
    logic          is_store;
  } mem_entry_t;

  logic [W_PORTS_NUM-1:0] busy_reg;
  logic [W_PORTS_NUM-1:0] rsv_reg;
  logic [W_PORTS_NUM-1:0] free_ports;
  logic [PW-1:0]          rr_ptr;

  logic [PW-1:0]          cand;
  logic                   cand_vld;
  logic [PW-1:0]          op3;
  logic                   op3_vld;

  instr_class_e           cls;
  logic                   is_cfg;
  logic                   is_mem;
  logic                   mem_ok;
  logic                   accept;
  logic                   alloc_go;
  logic                   op3_grant;

  mem_entry_t             fifo_mem [MEM_DEPTH];
  mem_entry_t             head;
  logic [MPW-1:0]         rd_ptr;
  logic [MPW-1:0]         wr_ptr;
  logic [CW-1:0]          mem_cnt;
  logic                   mem_empty;
  logic                   mem_full;
  logic                   mem_push;
  logic                   mem_pop;

  function automatic logic [MPW-1:0] ptr_inc(input logic [MPW-1:0] p);
    return (p == MPW'(MEM_DEPTH - 1)) ? '0 : p + MPW'(1);
  endfunction

  assign free_ports = ~(busy_reg | rsv_reg);
  assign all_idle_o = ((busy_reg | rsv_reg) == '0);

  // Round-robin candidate: first free port at or after rr_ptr.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cand     = '0;
    cand_vld = 1'b0;
    for (int i = 0; i < W_PORTS_NUM; i++) begin
      if (!cand_vld && free_ports[rr_ptr + PW'(i)]) begin
        cand     = rr_ptr + PW'(i);
        cand_vld = 1'b1;
      end
    end
  end

  // Third-operand port: first free port after cand, never cand itself.
  always_comb begin
    op3     = '0;
    op3_vld = 1'b0;
    for (int i = 1; i < W_PORTS_NUM; i++) begin
      if (!op3_vld && free_ports[cand + PW'(i)]) begin
        op3     = cand + PW'(i);
        op3_vld = 1'b1;
      end
    end
  end

  assign cls       = instr_class_e'(instr_class_i);
  assign is_cfg    = (cls == CLS_CONFIG);
  assign is_mem    = (cls == CLS_STORE) || (cls == CLS_LOAD);
  assign head      = fifo_mem[rd_ptr];
  assign mem_empty = (mem_cnt == '0);
  assign mem_full  = (mem_cnt == CW'(MEM_DEPTH));

  // Loads and stores are never mixed in flight, so the head's class stands for the FIFO.
  assign mem_ok = !is_mem ||
                  (!mem_full && (mem_empty || (head.is_store == (cls == CLS_STORE))));

  always_comb begin
    if (is_cfg) begin
      instr_rdy_o = all_idle_o && mem_empty && (dep_issue_i == '0);
    end else begin
      instr_rdy_o = vrf_addr_vld_i && (dep_issue_i == '0) && cand_vld &&
                    (!op3_req_i || op3_vld) && mem_ok;
    end
  end

  assign accept    = instr_vld_i && instr_rdy_o;
  assign alloc_go  = accept && !is_cfg;
  assign op3_grant = alloc_go && op3_req_i;
  assign mem_push  = alloc_go && is_mem;
  assign mem_pop   = !mem_empty && port_done_i[head.port];

  assign start_o        = alloc_go ? (W_PORTS_NUM'(1) << cand) : '0;
  assign alloc_port_o   = alloc_go ? cand : '0;
  assign op3_port_sel_o = op3;
  assign op3_port_vld_o = op3_grant;

  assign mem_driver_vld_o = !mem_empty;
  assign mem_driver_o     = mem_empty ? '0 : head.port;
  assign mem_is_store_o   = mem_empty ? 1'b0 : head.is_store;

  // Starts only target free ports, so a set never collides with a done on the same bit.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      busy_reg <= '0;
      rsv_reg  <= '0;
      rr_ptr   <= '0;
    end else begin
      busy_reg <= (busy_reg & ~port_done_i) | start_o;
      rsv_reg  <= (rsv_reg & ~port_done_i) |
                  (op3_grant ? (W_PORTS_NUM'(1) << op3) : '0);
      if (alloc_go) begin
        rr_ptr <= cand + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      mem_cnt <= '0;
    end else begin
      if (mem_push) wr_ptr <= ptr_inc(wr_ptr);
      if (mem_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({mem_push, mem_pop})
        2'b10:   mem_cnt <= mem_cnt + CW'(1);
        2'b01:   mem_cnt <= mem_cnt - CW'(1);
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; entries are only read while mem_cnt covers them.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      fifo_mem[wr_ptr] <= '{port: cand, is_store: (cls == CLS_STORE)};
    end
  end

endmodule

// File: tb/tb_port_alloc_scheduler.sv
// Directed self-checking bench for port_alloc_scheduler (W_PORTS_NUM=4, MEM_DEPTH=2).
module tb_port_alloc_scheduler;

  logic       clk = 1'b0;
  logic       rstn;
  logic       instr_vld_i;
  logic [1:0] instr_class_i;
  logic       op3_req_i;
  logic       vrf_addr_vld_i;
  logic [3:0] dep_issue_i;
  logic [3:0] port_done_i;
  logic       instr_rdy_o;
  logic [3:0] start_o;
  logic [1:0] alloc_port_o;
  logic [1:0] op3_port_sel_o;
  logic       op3_port_vld_o;
  logic [1:0] mem_driver_o;
  logic       mem_driver_vld_o;
  logic       mem_is_store_o;
  logic       all_idle_o;

  int n_checks = 0;
  int n_fails  = 0;

  port_alloc_scheduler #(.W_PORTS_NUM(4), .MEM_DEPTH(2)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .instr_vld_i      (instr_vld_i),
    .instr_class_i    (instr_class_i),
    .op3_req_i        (op3_req_i),
    .vrf_addr_vld_i   (vrf_addr_vld_i),
    .dep_issue_i      (dep_issue_i),
    .port_done_i      (port_done_i),
    .instr_rdy_o      (instr_rdy_o),
    .start_o          (start_o),
    .alloc_port_o     (alloc_port_o),
    .op3_port_sel_o   (op3_port_sel_o),
    .op3_port_vld_o   (op3_port_vld_o),
    .mem_driver_o     (mem_driver_o),
    .mem_driver_vld_o (mem_driver_vld_o),
    .mem_is_store_o   (mem_is_store_o),
    .all_idle_o       (all_idle_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, then let combinational outputs settle before sampling.
  task automatic apply(input logic vld, input logic [1:0] cls, input logic op3,
                       input logic [3:0] done);
    instr_vld_i   = vld;
    instr_class_i = cls;
    op3_req_i     = op3;
    port_done_i   = done;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    apply(1'b0, 2'd0, 1'b0, 4'b0000);
    tick();
    tick();
    rstn = 1'b1;
  endtask

  logic [3:0] exp_start;

  initial begin
    vrf_addr_vld_i = 1'b1;
    dep_issue_i    = '0;
    do_reset();
    apply(1'b0, 2'd0, 1'b0, 4'b0000);
    check("rst_start", start_o, 0);
    check("rst_op3_vld", op3_port_vld_o, 0);
    check("rst_mem_vld", mem_driver_vld_o, 0);
    check("rst_all_idle", all_idle_o, 1);

    // Issue gates: hazard flag and missing VRF address both block.
    dep_issue_i = 4'b0001;
    apply(1'b1, 2'd0, 1'b0, 4'b0000);
    check("dep_blocks_rdy", instr_rdy_o, 0);
    check("dep_blocks_start", start_o, 0);
    dep_issue_i    = '0;
    vrf_addr_vld_i = 1'b0;
    apply(1'b1, 2'd0, 1'b0, 4'b0000);
    check("vrf_blocks_rdy", instr_rdy_o, 0);
    vrf_addr_vld_i = 1'b1;

    // Four back-to-back arith accepts walk the ports, then no port is left.
    exp_start = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 2'd0, 1'b0, 4'b0000);
      check("rr_rdy", instr_rdy_o, 1);
      check("rr_start", start_o, exp_start);
      check("rr_alloc", alloc_port_o, i);
      exp_start = exp_start << 1;
      tick();
    end
    apply(1'b1, 2'd0, 1'b0, 4'b0000);
    check("full_rdy", instr_rdy_o, 0);
    check("full_start", start_o, 0);
    apply(1'b0, 2'd0, 1'b0, 4'b1111);
    tick();

    // Build port 1 busy with rr_ptr=1.
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 2'd0, 1'b0, 4'b0000);
      tick();
    end
    apply(1'b0, 2'd0, 1'b0, 4'b1101);
    tick();
    apply(1'b1, 2'd0, 1'b0, 4'b0000);
    check("setup_start", start_o, 4'b0001);
    tick();
    apply(1'b0, 2'd0, 1'b0, 4'b0001);
    tick();
    apply(1'b1, 2'd0, 1'b1, 4'b0000);
    check("op3_rdy", instr_rdy_o, 1);
    check("op3_start", start_o, 4'b0100);
    check("op3_sel", op3_port_sel_o, 3);
    check("op3_vld", op3_port_vld_o, 1);
    tick();
    apply(1'b1, 2'd0, 1'b1, 4'b0000);
    check("op3_blocked_rdy", instr_rdy_o, 0);
    check("op3_blocked_vld", op3_port_vld_o, 0);
    apply(1'b1, 2'd0, 1'b1, 4'b0010);
    check("op3_done_same_cyc", instr_rdy_o, 0);
    tick();
    apply(1'b1, 2'd0, 1'b1, 4'b0000);
    check("op3_after_done_rdy", instr_rdy_o, 1);
    check("op3_after_done_start", start_o, 4'b0001);
    check("op3_after_done_sel", op3_port_sel_o, 1);
    tick();
    apply(1'b0, 2'd0, 1'b0, 4'b1111);
    tick();
    apply(1'b0, 2'd0, 1'b0, 4'b0000);
    check("op3_cleanup_idle", all_idle_o, 1);

    // Store FIFO depth limit.
    do_reset();
    apply(1'b1, 2'd1, 1'b0, 4'b0000);
    check("st0_start", start_o, 4'b0001);
    tick();
    apply(1'b1, 2'd1, 1'b0, 4'b0000);
    check("st1_start", start_o, 4'b0010);
    tick();
    apply(1'b1, 2'd1, 1'b0, 4'b0000);
    check("st_full_rdy", instr_rdy_o, 0);
    check("st_head", mem_driver_o, 0);
    check("st_head_vld", mem_driver_vld_o, 1);
    check("st_head_store", mem_is_store_o, 1);
    apply(1'b1, 2'd1, 1'b0, 4'b0001);
    check("st_full_done_cyc", instr_rdy_o, 0);
    tick();
    apply(1'b1, 2'd1, 1'b0, 4'b0000);
    check("st_pop_head", mem_driver_o, 1);
    check("st_pop_rdy", instr_rdy_o, 1);
    check("st2_start", start_o, 4'b0100);
    tick();
    apply(1'b0, 2'd0, 1'b0, 4'b0010);
    tick();
    apply(1'b0, 2'd0, 1'b0, 4'b0100);
    tick();
    apply(1'b0, 2'd0, 1'b0, 4'b0000);
    check("st_drain_vld", mem_driver_vld_o, 0);
    check("st_drain_idle", all_idle_o, 1);

    // Load waits for the outstanding store to retire.
    apply(1'b1, 2'd1, 1'b0, 4'b0000);
    check("mix_st_start", start_o, 4'b1000);
    tick();
    apply(1'b1, 2'd2, 1'b0, 4'b0000);
    check("mix_ld_blocked", instr_rdy_o, 0);
    apply(1'b1, 2'd2, 1'b0, 4'b1000);
    check("mix_ld_done_cyc", instr_rdy_o, 0);
    tick();
    apply(1'b1, 2'd2, 1'b0, 4'b0000);
    check("mix_ld_rdy", instr_rdy_o, 1);
    check("mix_ld_start", start_o, 4'b0001);
    tick();
    apply(1'b0, 2'd0, 1'b0, 4'b0000);
    check("mix_ld_is_store", mem_is_store_o, 0);
    check("mix_ld_vld", mem_driver_vld_o, 1);
    check("mix_ld_head", mem_driver_o, 0);
    apply(1'b0, 2'd0, 1'b0, 4'b0001);
    tick();

    // Config waits for every port to go idle and never starts a port.
    apply(1'b1, 2'd0, 1'b0, 4'b0000);
    check("cfg_setup1", start_o, 4'b0010);
    tick();
    apply(1'b0, 2'd0, 1'b0, 4'b0010);
    tick();
    apply(1'b1, 2'd0, 1'b0, 4'b0000);
    check("cfg_setup2", start_o, 4'b0100);
    tick();
    apply(1'b1, 2'd3, 1'b0, 4'b0000);
    check("cfg_busy_rdy", instr_rdy_o, 0);
    apply(1'b1, 2'd3, 1'b0, 4'b0100);
    check("cfg_done_cyc_rdy", instr_rdy_o, 0);
    tick();
    apply(1'b1, 2'd3, 1'b0, 4'b0000);
    check("cfg_idle", all_idle_o, 1);
    check("cfg_rdy", instr_rdy_o, 1);
    check("cfg_start", start_o, 0);
    check("cfg_op3_vld", op3_port_vld_o, 0);
    tick();
    apply(1'b0, 2'd0, 1'b0, 4'b0000);
    check("cfg_after_idle", all_idle_o, 1);

    // Reset mid-operation abandons busy ports and FIFO entries.
    apply(1'b1, 2'd1, 1'b0, 4'b0000);
    check("mid_st_a", start_o, 4'b1000);
    tick();
    apply(1'b1, 2'd1, 1'b0, 4'b0000);
    check("mid_st_b", start_o, 4'b0001);
    tick();
    apply(1'b1, 2'd0, 1'b0, 4'b0000);
    check("mid_ar", start_o, 4'b0010);
    tick();
    apply(1'b0, 2'd0, 1'b0, 4'b0000);
    check("mid_busy", all_idle_o, 0);
    check("mid_mem_vld", mem_driver_vld_o, 1);
    check("mid_mem_head", mem_driver_o, 3);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    apply(1'b0, 2'd0, 1'b0, 4'b0000);
    check("mid_rst_idle", all_idle_o, 1);
    check("mid_rst_mem_vld", mem_driver_vld_o, 0);
    check("mid_rst_start", start_o, 0);
    apply(1'b1, 2'd0, 1'b0, 4'b0000);
    check("mid_rst_first", start_o, 4'b0001);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
